// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package riscv_mem_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port memory.
// Data accesses win, but a waiting fetch is forced through after MAX_DM_STREAK data grants.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  owner_t        owner;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          grant_dm;
  logic          grant_if;
  logic [DW-1:0] done_rdata;

  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      grant_dm = dm_req && !(if_req && streak == STREAK_MAX);
      grant_if = if_req && !grant_dm;
    end
  end

  // Writes and aborted accesses both return zero to the owner.
  assign done_rdata = (mem_ready && !mem_we) ? mem_rdata : '0;

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      streak <= '0;
    else if (!if_req || grant_if)
      streak <= '0;
    else if (grant_dm && streak != STREAK_MAX)
      streak <= streak + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      timer     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (grant_dm) begin
            owner     <= OWN_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= MEM;
          end else if (grant_if) begin
            owner     <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= MEM;
          end
        end
        MEM: begin
          // The final timer cycle still accepts a late mem_ready.
          if (mem_ready || timer == TIMER_LAST) begin
            mem_req <= 1'b0;
            err     <= !mem_ready;
            state   <= DONE;
            if (owner == OWN_IF) begin
              if_valid <= 1'b1;
              if_rdata <= done_rdata;
            end else begin
              dm_valid <= 1'b1;
              dm_rdata <= done_rdata;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the grant rule and memory contents.
module tb_riscv_mem_arbiter;
  import riscv_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_DM_STREAK = 4;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic          if_valid, dm_valid, err, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int mem_wait = 0, cur_wait = 0, wcnt = 0;
  bit mem_hang = 1'b0, mem_rand_wait = 1'b0;

  riscv_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DM_STREAK(MAX_DM_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_read(logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Unified memory with programmable wait states; ready is noise while no access is open.
  always @(negedge clk) begin
    if (mem_req) begin
      if (!mem_hang && wcnt >= cur_wait) begin
        mem_ready = 1'b1;
        mem_rdata = mem_read(mem_addr);
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      wcnt++;
    end else begin
      wcnt = 0;
      cur_wait = mem_rand_wait ? int'($urandom_range(0, 3)) : mem_wait;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, if_valid, dm_valid, err} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got %b want 00000", {mem_req, mem_we, if_valid, dm_valid, err});
    end
    vectors++;
    if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_buses got %h %h %h %h want 0", if_rdata, dm_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req, if_valid, dm_valid} !== 3'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle got %b want 000", {mem_req, if_valid, dm_valid});
    end
  endtask

  task automatic test_lone_fetch();
    mem_wait = 0;
    mem_arr[32'h10] = 32'h0050_0093;
    if_addr = 32'h10;
    if_req = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_addr, if_valid} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL fetch_issue got req=%b we=%b addr=%h valid=%b want 1 0 10 0", mem_req, mem_we, mem_addr, if_valid);
    end
    @(negedge clk);
    vectors++;
    if ({if_valid, err, dm_valid, if_rdata} !== {3'b100, 32'h0050_0093}) begin
      miscompares++;
      $display("[TB] FAIL fetch_done got valid=%b err=%b dvalid=%b rdata=%h want 1 0 0 00500093", if_valid, err, dm_valid, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if_valid, if_rdata} !== {1'b0, 32'h0050_0093}) begin
      miscompares++;
      $display("[TB] FAIL fetch_hold got valid=%b rdata=%h want 0 00500093", if_valid, if_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_wait();
    mem_wait = 3;
    dm_we = 1'b1;
    dm_addr = 32'h20;
    dm_wdata = 32'hDEAD_BEEF;
    dm_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, dm_valid} !== {2'b11, 32'h20, 32'hDEAD_BEEF, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL write_hold cycle %0d got req=%b we=%b addr=%h wdata=%h valid=%b", c, mem_req, mem_we, mem_addr, mem_wdata, dm_valid);
      end
    end
    @(negedge clk);
    vectors++;
    if ({dm_valid, err, mem_req, dm_rdata} !== {3'b100, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL write_done got valid=%b err=%b req=%b rdata=%h want 1 0 0 0", dm_valid, err, mem_req, dm_rdata);
    end
    dm_req = 1'b0;
    dm_we = 1'b0;
    mem_wait = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_contention();
    owner_t seq[$];
    owner_t exp_own;
    int cyc = 0;
    if_addr = 32'h100;
    dm_addr = 32'h200;
    dm_we = 1'b0;
    if_req = 1'b1;
    dm_req = 1'b1;
    while (seq.size() < 15 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (if_valid) seq.push_back(OWN_IF);
      if (dm_valid) seq.push_back(OWN_DM);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    vectors++;
    if (seq.size() != 15) begin
      miscompares++;
      $display("[TB] FAIL contention_count got %0d completions want 15", seq.size());
    end
    foreach (seq[i]) begin
      exp_own = (i % 5 == 4) ? OWN_IF : OWN_DM;
      vectors++;
      if (seq[i] !== exp_own) begin
        miscompares++;
        $display("[TB] FAIL contention_order slot %0d got %s want %s", i, seq[i].name(), exp_own.name());
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    mem_hang = 1'b1;
    if_addr = 32'h40;
    if_req = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      vectors++;
      if ({mem_req, if_valid} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL timeout_hold cycle %0d got req=%b valid=%b want 1 0", c, mem_req, if_valid);
      end
    end
    @(negedge clk);
    vectors++;
    if ({mem_req, if_valid, err, if_rdata} !== {3'b011, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL timeout_done got req=%b valid=%b err=%b rdata=%h want 0 1 1 0", mem_req, if_valid, err, if_rdata);
    end
    if_req = 1'b0;
    mem_hang = 1'b0;
    @(negedge clk);
    dm_addr = 32'h10;
    dm_we = 1'b0;
    dm_req = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({dm_valid, err, dm_rdata} !== {2'b10, 32'h0050_0093}) begin
      miscompares++;
      $display("[TB] FAIL timeout_recover got valid=%b err=%b rdata=%h want 1 0 00500093", dm_valid, err, dm_rdata);
    end
    dm_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    owner_t seq[$];
    owner_t exp_own;
    int cyc = 0;
    int dm_cnt = 0;
    if_addr = 32'h100;
    dm_addr = 32'h200;
    dm_we = 1'b0;
    if_req = 1'b1;
    dm_req = 1'b1;
    while (dm_cnt < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (dm_valid) dm_cnt++;
    end
    mem_hang = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_req && cyc < 10);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_open got req=%b want 1", mem_req);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({mem_req, if_rdata, dm_rdata} !== 65'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_drop got req=%b irdata=%h drdata=%h want 0 0 0", mem_req, if_rdata, dm_rdata);
    end
    mem_hang = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({mem_req, if_valid, dm_valid} !== 3'b0) begin
        miscompares++;
        $display("[TB] FAIL rstmid_quiet got %b want 000", {mem_req, if_valid, dm_valid});
      end
    end
    rst = 1'b1;
    cyc = 0;
    while (seq.size() < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (if_valid) seq.push_back(OWN_IF);
      if (dm_valid) seq.push_back(OWN_DM);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    vectors++;
    if (seq.size() != 5) begin
      miscompares++;
      $display("[TB] FAIL rstmid_count got %0d completions want 5", seq.size());
    end
    foreach (seq[i]) begin
      exp_own = (i == 4) ? OWN_IF : OWN_DM;
      vectors++;
      if (seq[i] !== exp_own) begin
        miscompares++;
        $display("[TB] FAIL rstmid_order slot %0d got %s want %s", i, seq[i].name(), exp_own.name());
      end
    end
    repeat (3) @(negedge clk);
    if_addr = 32'h10;
    if_req = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({if_valid, err, if_rdata} !== {2'b10, 32'h0050_0093}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_fetch got valid=%b err=%b rdata=%h want 1 0 00500093", if_valid, err, if_rdata);
    end
    if_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    logic [3:0] want;
    logic [31:0] exp_rd;
    exp_rd = init_word(32'h30);
    dm_addr = 32'h30;
    dm_we = 1'b0;
    dm_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      got = {mem_req, dm_valid, if_valid, err};
      case (c)
        1, 4:    want = 4'b1000;
        2, 5:    want = 4'b0100;
        default: want = 4'b0000;
      endcase
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL b2b cycle %0d got req/dv/iv/err=%b want %b", c, got, want);
      end
    end
    vectors++;
    if (dm_rdata !== exp_rd) begin
      miscompares++;
      $display("[TB] FAIL b2b_rdata got %h want %h", dm_rdata, exp_rd);
    end
    dm_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    bit if_pend = 0, dm_pend = 0, prev_mreq = 0, busy = 0;
    bit p_if, p_dm, p_we;
    logic [31:0] p_iaddr, p_daddr, p_wdata, exp_rd, obs;
    owner_t cur_own = OWN_IF;
    int dm_run = 0, if_wait = 0, max_if_wait = 0, completions = 0, prob;
    mem_arr.delete();
    ref_mem.delete();
    mem_rand_wait = 1'b1;
    @(negedge clk);
    prev_mreq = mem_req;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      p_if = if_req; p_dm = dm_req; p_we = dm_we;
      p_iaddr = if_addr; p_daddr = dm_addr; p_wdata = dm_wdata;
      @(negedge clk);
      if (mem_req && !prev_mreq) begin
        vectors++;
        if (p_dm && !(p_if && dm_run == MAX_DM_STREAK)) begin
          cur_own = OWN_DM;
          if ({mem_addr, mem_we} !== {p_daddr, p_we} || (p_we && mem_wdata !== p_wdata)) begin
            miscompares++;
            $display("[TB] FAIL rand_dm_grant got addr=%h we=%b wd=%h want %h %b %h", mem_addr, mem_we, mem_wdata, p_daddr, p_we, p_wdata);
          end
          if (p_we) begin
            ref_mem[p_daddr] = p_wdata;
            exp_rd = '0;
          end else begin
            exp_rd = ref_read(p_daddr);
          end
          dm_run = p_if ? ((dm_run < MAX_DM_STREAK) ? dm_run + 1 : dm_run) : 0;
        end else if (p_if) begin
          cur_own = OWN_IF;
          if ({mem_addr, mem_we} !== {p_iaddr, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rand_if_grant got addr=%h we=%b want %h 0", mem_addr, mem_we, p_iaddr);
          end
          exp_rd = ref_read(p_iaddr);
          dm_run = 0;
        end else begin
          miscompares++;
          $display("[TB] FAIL rand_spurious_grant got mem_req=1 want 0");
        end
        busy = 1'b1;
      end else if (!p_if) begin
        dm_run = 0;
      end
      if (if_valid || dm_valid) begin
        vectors++;
        if (!busy || !prev_mreq || mem_req || (if_valid && dm_valid) ||
            (cur_own == OWN_IF ? !if_valid : !dm_valid)) begin
          miscompares++;
          $display("[TB] FAIL rand_valid got iv=%b dv=%b req=%b want owner %s after access", if_valid, dm_valid, mem_req, cur_own.name());
        end
        obs = (cur_own == OWN_IF) ? if_rdata : dm_rdata;
        vectors++;
        if ({err, obs} !== {1'b0, exp_rd}) begin
          miscompares++;
          $display("[TB] FAIL rand_rdata got err=%b rdata=%h want 0 %h", err, obs, exp_rd);
        end
        busy = 1'b0;
        completions++;
        if (if_valid) if_pend = 1'b0;
        if (dm_valid) dm_pend = 1'b0;
      end
      prev_mreq = mem_req;
      if (if_pend) if_wait++; else if_wait = 0;
      if (if_wait > max_if_wait) max_if_wait = if_wait;
      prob = (cyc % 1000 < 300) ? 100 : 50;
      if (!if_pend && int'($urandom_range(0, 99)) < prob) begin
        if_pend = 1'b1;
        if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!dm_pend && int'($urandom_range(0, 99)) < prob) begin
        dm_pend = 1'b1;
        dm_addr = 32'($urandom_range(0, 63)) << 2;
        dm_we = 1'($urandom_range(0, 1));
        dm_wdata = $urandom;
      end
      if_req = if_pend;
      dm_req = dm_pend;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    mem_rand_wait = 1'b0;
    vectors++;
    if (max_if_wait > 40 || completions < 300) begin
      miscompares++;
      $display("[TB] FAIL rand_progress got max_if_wait=%0d completions=%0d want <=40 and >=300", max_if_wait, completions);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_write_wait();
    test_contention();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
